// File: rtl/div_operand_stage.sv
// div_operand_stage: registers a divide request, normalises the divisor by
// left shifts, launches the datapath and waits for done.
// Optional DIV_ZERO_BYPASS_EN: a zero divisor is answered locally (spec_*).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_usigned_n, req_dividend,
//   req_divisor                     request operands
//   dp_start                        one-cycle launch pulse
//   dp_usigned_n, dp_dividend,
//   dp_divisor, dp_shift            registered/normalised operands
//   dp_done                         datapath finished pulse
//   spec_valid, spec_quotient,
//   spec_reminder                   divide-by-zero result pulse
module div_operand_stage #(
    parameter  int parallelism = 32,
    localparam int SW = $clog2(parallelism) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_usigned_n,
    input  logic [parallelism-1:0] req_dividend,
    input  logic [parallelism-1:0] req_divisor,
    output logic                   dp_start,
    output logic                   dp_usigned_n,
    output logic [parallelism-1:0] dp_dividend,
    output logic [parallelism-1:0] dp_divisor,
    output logic [SW-1:0]          dp_shift,
    input  logic                   dp_done,
    output logic                   spec_valid,
    output logic [parallelism-1:0] spec_quotient,
    output logic [parallelism-1:0] spec_reminder
);

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        ISSUE,
        WAIT
`ifdef DIV_ZERO_BYPASS_EN
        , SPECIAL
`endif
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic                   usigned_n;
    logic [parallelism-1:0] dividend;
    logic [parallelism-1:0] divisor;
    logic [SW-1:0]          shift;
    logic                   accept;
    logic                   is_norm;
    logic                   top_ok;

    assign accept = (state == IDLE) && req_valid;

    // Signed operands are normalised once the sign bit differs from the
    // next bit; the shift cap stops an all-ones signed divisor from looping.
    assign top_ok  = usigned_n ? (divisor[parallelism-1] ^ divisor[parallelism-2])
                               : divisor[parallelism-1];
    assign is_norm = (divisor == '0)
                  || (shift == SW'(parallelism - 1))
                  || top_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
`ifdef DIV_ZERO_BYPASS_EN
                    if (req_divisor == '0) begin
                        state_n = SPECIAL;
                    end else begin
                        state_n = NORM;
                    end
`else
                    state_n = NORM;
`endif
                end
            end
            NORM: begin
                if (is_norm) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (dp_done) begin
                    state_n = IDLE;
                end
            end
`ifdef DIV_ZERO_BYPASS_EN
            SPECIAL: begin
                state_n = IDLE;
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            usigned_n <= 1'b0;
            dividend  <= '0;
            divisor   <= '0;
            shift     <= '0;
        end else if (accept) begin
            usigned_n <= req_usigned_n;
            dividend  <= req_dividend;
            divisor   <= req_divisor;
            shift     <= '0;
        end else if ((state == NORM) && !is_norm) begin
            divisor <= {divisor[parallelism-2:0], 1'b0};
            shift   <= shift + SW'(1);
        end
    end

    assign req_ready    = (state == IDLE);
    assign dp_start     = (state == ISSUE);
    assign dp_usigned_n = usigned_n;
    assign dp_dividend  = dividend;
    assign dp_divisor   = divisor;
    assign dp_shift     = shift;

`ifdef DIV_ZERO_BYPASS_EN
    assign spec_valid    = (state == SPECIAL);
    assign spec_quotient = {parallelism{spec_valid}};
    assign spec_reminder = spec_valid ? dividend : '0;
`else
    assign spec_valid    = 1'b0;
    assign spec_quotient = '0;
    assign spec_reminder = '0;
`endif

endmodule

// File: tb/tb_div_operand_stage.sv
// Testbench for div_operand_stage: scoreboarded requests, normalisation,
// reset, zero-divisor handling and back-to-back acceptance.
module tb_div_operand_stage;

    localparam int P  = 32;
    localparam int SW = $clog2(P) + 1;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_usigned_n;
    logic [P-1:0]  req_dividend;
    logic [P-1:0]  req_divisor;
    logic          dp_start;
    logic          dp_usigned_n;
    logic [P-1:0]  dp_dividend;
    logic [P-1:0]  dp_divisor;
    logic [SW-1:0] dp_shift;
    logic          dp_done;
    logic          spec_valid;
    logic [P-1:0]  spec_quotient;
    logic [P-1:0]  spec_reminder;

    div_operand_stage #(.parallelism(P)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_usigned_n (req_usigned_n),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .dp_start      (dp_start),
        .dp_usigned_n  (dp_usigned_n),
        .dp_dividend   (dp_dividend),
        .dp_divisor    (dp_divisor),
        .dp_shift      (dp_shift),
        .dp_done       (dp_done),
        .spec_valid    (spec_valid),
        .spec_quotient (spec_quotient),
        .spec_reminder (spec_reminder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          usn;
        logic [P-1:0]  dvd;
        logic [P-1:0]  dvs;
        logic [SW-1:0] sh;
        int            lat;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic exp_t model(logic usn, logic [P-1:0] dvd, logic [P-1:0] dvs);
        exp_t         e;
        int           s = 0;
        logic [P-1:0] d = dvs;
        while (!(d == 0 || s == P - 1 || (usn ? (d[P-1] != d[P-2]) : d[P-1]))) begin
            d = d << 1;
            s++;
        end
        e.usn = usn;
        e.dvd = dvd;
        e.dvs = d;
        e.sh  = SW'(s);
        e.lat = s + 2;
        return e;
    endfunction

    task automatic send(input logic usn, input logic [P-1:0] dvd, input logic [P-1:0] dvs);
        int n = 0;
        @(negedge clk);
        req_valid     = 1'b1;
        req_usigned_n = usn;
        req_dividend  = dvd;
        req_divisor   = dvs;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 200) begin
            miscompares++;
            $display("FAIL send_ready: got ready=%b want 1 within 200 cycles", req_ready);
        end
`ifdef DIV_ZERO_BYPASS_EN
        if (dvs != 0) sbq.push_back(model(usn, dvd, dvs));
`else
        sbq.push_back(model(usn, dvd, dvs));
`endif
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_start(input int from, output int lat);
        lat = from;
        do begin
            @(negedge clk);
            lat++;
        end while (!dp_start && lat < P + 8);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        int   lat;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || dp_start !== 1'b0 || spec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got rdy=%b st=%b sv=%b want 1 0 0",
                     req_ready, dp_start, spec_valid);
        end
        vectors++;
        if ({dp_shift, dp_divisor, dp_dividend, dp_usigned_n, spec_quotient, spec_reminder} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got sh=%h dvs=%h dvd=%h want all 0",
                     dp_shift, dp_divisor, dp_dividend);
        end
        rst_n = 1'b1;
        send(1'b0, 32'd50, 32'd5);
        wait_start(0, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== e.lat || dp_shift !== e.sh) begin
            miscompares++;
            $display("FAIL rst_pre_start: got lat=%0d sh=%0d want lat=%0d sh=%0d",
                     lat, dp_shift, e.lat, e.sh);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (req_ready !== 1'b1 || dp_start !== 1'b0 || dp_shift !== '0 || dp_divisor !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_wait: got rdy=%b st=%b sh=%h dvs=%h want 1 0 0 0",
                     req_ready, dp_start, dp_shift, dp_divisor);
        end
        pulse_done();
        repeat (2) @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || dp_start !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_late_done: got rdy=%b st=%b want 1 0", req_ready, dp_start);
        end
    endtask

    task automatic test_unsigned_norm();
        exp_t e;
        int   lat;
        logic bad = 1'b0;
        send(1'b0, 32'd100, 32'h8000_0000);
        wait_start(0, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== 2 || lat !== e.lat) begin
            miscompares++;
            $display("FAIL un_lat: got %0d want 2", lat);
        end
        vectors++;
        if (dp_shift !== 0 || dp_divisor !== 32'h8000_0000 || dp_divisor !== e.dvs) begin
            miscompares++;
            $display("FAIL un_norm: got sh=%0d dvs=%h want 0 80000000", dp_shift, dp_divisor);
        end
        vectors++;
        if ({dp_usigned_n, dp_dividend} !== {e.usn, e.dvd}) begin
            miscompares++;
            $display("FAIL un_opnd: got %b/%h want %b/%h", dp_usigned_n, dp_dividend, e.usn, e.dvd);
        end
        repeat (3) begin
            @(negedge clk);
            if (dp_start !== 1'b0 || req_ready !== 1'b0 || dp_divisor !== e.dvs || dp_shift !== e.sh)
                bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL un_wait_hold: got unstable=%b want 0", bad);
        end
        pulse_done();
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL un_ready_after_done: got %b want 1", req_ready);
        end
    endtask

    task automatic test_cap();
        exp_t e;
        int   lat;
        send(1'b0, 32'd7, 32'd1);
        pulse_done();
        wait_start(2, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== P + 1 || lat !== e.lat) begin
            miscompares++;
            $display("FAIL cap_lat: got %0d want %0d", lat, P + 1);
        end
        vectors++;
        if (dp_shift !== 31 || dp_divisor !== 32'h8000_0000 || dp_shift !== e.sh) begin
            miscompares++;
            $display("FAIL cap_norm: got sh=%0d dvs=%h want 31 80000000", dp_shift, dp_divisor);
        end
        pulse_done();
        send(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_start(0, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== P + 1 || dp_shift !== 31 || dp_divisor !== 32'h8000_0000
            || dp_dividend !== 32'h8000_0000 || dp_usigned_n !== 1'b1) begin
            miscompares++;
            $display("FAIL cap_signed: got lat=%0d sh=%0d dvs=%h dvd=%h want %0d 31 80000000 80000000",
                     lat, dp_shift, dp_divisor, dp_dividend, e.lat);
        end
        pulse_done();
    endtask

    task automatic test_signed();
        exp_t e;
        int   lat;
        send(1'b1, 32'hFFFF_FFEC, 32'd3);
        wait_start(0, lat);
        e = sbq.pop_front();
        vectors++;
        if (dp_shift !== 29 || dp_divisor !== 32'h6000_0000 || lat !== 31) begin
            miscompares++;
            $display("FAIL sg_norm: got sh=%0d dvs=%h lat=%0d want 29 60000000 31",
                     dp_shift, dp_divisor, lat);
        end
        vectors++;
        if (dp_dividend !== 32'hFFFF_FFEC || dp_usigned_n !== 1'b1 || dp_dividend !== e.dvd) begin
            miscompares++;
            $display("FAIL sg_opnd: got %b/%h want 1/ffffffec", dp_usigned_n, dp_dividend);
        end
        pulse_done();
    endtask

    task automatic test_zero();
`ifdef DIV_ZERO_BYPASS_EN
        send(1'b0, 32'h1234, 32'd0);
        @(negedge clk);
        vectors++;
        if (spec_valid !== 1'b1 || spec_quotient !== 32'hFFFF_FFFF
            || spec_reminder !== 32'h1234 || dp_start !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_spec: got v=%b q=%h r=%h st=%b want 1 ffffffff 1234 0",
                     spec_valid, spec_quotient, spec_reminder, dp_start);
        end
        @(negedge clk);
        vectors++;
        if (spec_valid !== 1'b0 || req_ready !== 1'b1 || dp_start !== 1'b0 || spec_quotient !== '0) begin
            miscompares++;
            $display("FAIL zero_after: got v=%b rdy=%b st=%b q=%h want 0 1 0 0",
                     spec_valid, req_ready, dp_start, spec_quotient);
        end
`else
        exp_t e;
        int   lat;
        send(1'b0, 32'h1234, 32'd0);
        wait_start(0, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== 2 || dp_shift !== 0 || dp_divisor !== 0 || lat !== e.lat) begin
            miscompares++;
            $display("FAIL zero_issue: got lat=%0d sh=%0d dvs=%h want 2 0 0", lat, dp_shift, dp_divisor);
        end
        vectors++;
        if (spec_valid !== 1'b0 || dp_dividend !== 32'h1234) begin
            miscompares++;
            $display("FAIL zero_nospec: got v=%b dvd=%h want 0 1234", spec_valid, dp_dividend);
        end
        pulse_done();
`endif
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        int   starts = 0;
        logic bad    = 1'b0;
        send(1'b0, 32'd1000, 32'h0000_0F00);
        wait_start(0, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== e.lat || dp_shift !== e.sh || dp_divisor !== e.dvs) begin
            miscompares++;
            $display("FAIL b2b_a: got lat=%0d sh=%0d dvs=%h want %0d %0d %h",
                     lat, dp_shift, dp_divisor, e.lat, e.sh, e.dvs);
        end
        @(negedge clk);
        req_valid     = 1'b1;
        req_usigned_n = 1'b1;
        req_dividend  = 32'hFFFF_0000;
        req_divisor   = 32'd5;
        sbq.push_back(model(1'b1, 32'hFFFF_0000, 32'd5));
        repeat (3) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || dp_divisor !== e.dvs || dp_dividend !== 32'd1000) bad = 1'b1;
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_hold: got accepted_in_wait=%b want 0", bad);
        end
        pulse_done();
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_idle: got rdy=%b want 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_start(0, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== e.lat || dp_shift !== e.sh || dp_divisor !== e.dvs
            || dp_dividend !== e.dvd || dp_usigned_n !== e.usn) begin
            miscompares++;
            $display("FAIL b2b_b: got lat=%0d sh=%0d dvs=%h dvd=%h want %0d %0d %h %h",
                     lat, dp_shift, dp_divisor, dp_dividend, e.lat, e.sh, e.dvs, e.dvd);
        end
        pulse_done();
        repeat (6) begin
            @(negedge clk);
            if (dp_start === 1'b1) starts++;
        end
        vectors++;
        if (starts !== 0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_once: got extra_starts=%0d rdy=%b want 0 1", starts, req_ready);
        end
    endtask

    task automatic test_random();
        exp_t         e;
        int           lat;
        logic [P-1:0] dvs;
        for (int i = 0; i < 10; i++) begin
            dvs = $urandom() >> $urandom_range(0, 31);
            if (dvs == 0) dvs = 32'd9;
            send(1'($urandom_range(0, 1)), $urandom(), dvs);
            wait_start(0, lat);
            e = sbq.pop_front();
            vectors++;
            if (lat !== e.lat || dp_shift !== e.sh || dp_divisor !== e.dvs
                || dp_dividend !== e.dvd || dp_usigned_n !== e.usn) begin
                miscompares++;
                $display("FAIL rnd_%0d: got lat=%0d sh=%0d dvs=%h want %0d %0d %h",
                         i, lat, dp_shift, dp_divisor, e.lat, e.sh, e.dvs);
            end
            pulse_done();
        end
    endtask

    initial begin
        req_valid     = 1'b0;
        req_usigned_n = 1'b0;
        req_dividend  = '0;
        req_divisor   = '0;
        dp_done       = 1'b0;
        test_reset();
        test_unsigned_norm();
        test_cap();
        test_signed();
        test_zero();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_operand_stage.md
# div_operand_stage

Front-end stage that sits directly upstream of the divider datapath and its control FSM. It accepts one divide request per transaction over a valid/ready handshake and registers the operands. It then normalises the divisor by iterative left shifts, recording the shift count used by the datapath iteration counter, and launches the datapath with a one-cycle start pulse. It stays busy until the datapath reports done; a zero divisor is optionally resolved locally without occupying the datapath.

## Interface
- parallelism, 32, operand width in bits (≥4)
- SW = $clog2(parallelism)+1, derived (localparam), shift-count width (6 at default)

- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  stage can accept (high only in IDLE)
- req_usigned_n  input  1  0 = unsigned, 1 = signed (two's complement)
- req_dividend  input  parallelism  dividend
- req_divisor  input  parallelism  divisor
- dp_start  output  1  one-cycle launch pulse to datapath/control
- dp_usigned_n  output  1  registered signedness
- dp_dividend  output  parallelism  registered dividend, unmodified
- dp_divisor  output  parallelism  normalised divisor
- dp_shift  output  SW  left shifts applied to divisor
- dp_done  input  1  datapath finished (single-cycle pulse)
- spec_valid  output  1  one-cycle pulse: divide-by-zero result ready (macro-gated)
- spec_quotient  output  parallelism  all ones when spec_valid
- spec_reminder  output  parallelism  dividend when spec_valid

## Operation
- States: IDLE, NORM, ISSUE, WAIT, SPECIAL.
- IDLE: req_ready=1. On req_valid, register dividend, divisor and usigned_n, and clear shift count.
  - If the divisor is zero and DIV_ZERO_BYPASS_EN is defined, go to SPECIAL.
  - Otherwise go to NORM.
- NORM: the normalised test is combinational on the divisor register.
  - Unsigned: normalised when bit[parallelism-1]=1.
  - Signed: normalised when bit[parallelism-1] ≠ bit[parallelism-2].
  - Zero divisor: treated as normalised immediately.
  - Shift count equal to parallelism-1: treated as normalised (cap).
  - If normalised, go to ISSUE. Otherwise shift the divisor left by 1 (zero fill), increment the shift count, and stay in NORM.
- ISSUE: dp_start=1 for exactly this cycle; go to WAIT.
- WAIT: hold all dp_* outputs stable; go to IDLE on dp_done.
- SPECIAL: spec_valid=1 for one cycle, spec_quotient={parallelism{1'b1}}, spec_reminder=dividend; go to IDLE.
- dp_done outside WAIT is ignored.
- req_valid outside IDLE is not accepted; the requester must hold its data.
- Signed overflow (most-negative / -1) is not special-cased; it is passed to the datapath.

## Timing
- Reset (async, any state): state=IDLE, req_ready=1, dp_start=0, spec_valid=0. All data registers, dp_shift and spec_* are 0. An in-flight operation is abandoned; a dp_done arriving after reset is ignored.
- Accept edge: the first edge with req_valid & req_ready.
- NORM occupies k+1 cycles for k shifts.
- dp_start is high in cycle k+2 after the accept edge, i.e. request-to-start latency is k+2 cycles (min 2, max parallelism+1).
- dp_divisor, dp_shift and dp_usigned_n are valid from the ISSUE cycle until leaving WAIT.
- req_ready returns high the cycle after dp_done is sampled.
- Zero-divisor bypass: spec_valid is high in the cycle after the accept edge; req_ready returns high one cycle later.
- Back-to-back: a request may be accepted on the first IDLE cycle after WAIT or SPECIAL.

## Configuration
- DIV_ZERO_BYPASS_EN defined: a zero divisor goes IDLE→SPECIAL and the datapath is never started.
- Undefined: the SPECIAL state and spec_* logic are removed, and spec_valid ties to 0. A zero divisor goes through NORM (1 cycle, shift 0) and ISSUE like any other operand.

## Test plan
- Reset mid-WAIT (rst_n low for 1 cycle) → req_ready=1, dp_start=0 next cycle; a later dp_done pulse causes no state change.
- Unsigned 100/0x8000_0000 → dp_start 2 cycles after accept, dp_shift=0, dp_divisor=0x8000_0000; req_ready=1 the cycle after dp_done.
- Unsigned 7/1 → dp_shift=31, dp_divisor=0x8000_0000, dp_start 33 cycles after accept.
- Signed -20/3 → dp_shift=29, dp_divisor=0x6000_0000, dp_dividend=0xFFFF_FFEC, dp_usigned_n=1.
- Divisor 0, dividend 0x1234, macro on → spec_valid 1 cycle after accept, spec_quotient=0xFFFF_FFFF, spec_reminder=0x1234, no dp_start. Macro off → dp_start with dp_shift=0, dp_divisor=0.
- req_valid held high through WAIT with a different operand → not accepted until IDLE; the second operand is latched exactly once.
